// File: rtl/seg7_scan_driver_pkg.sv
// ---------------------------------------------------------------------------
// clock_disp_pkg
// Shared types and constants for the clock display path: BCD digit codes,
// active-low segment patterns {g,f,e,d,c,b,a} and the digit lookup table.
// No ports (package).
// ---------------------------------------------------------------------------
package clock_disp_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  // Code the upstream mux sends for a dark digit (blink-off phase, reset)
  localparam bcd_t BCD_BLANK = 4'b1111;

  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b0111111;

  // Active-low patterns for decimal digits 0..9, bit order {g,f,e,d,c,b,a}
  localparam seg_t SEG_DIGITS [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver_if
// Bundles the digit inputs and the display outputs of seg7_scan_driver.
//   bcd3..bcd0  : digit codes from the view mux (bcd3 leftmost)
//   dp_colon    : colon request (only with SEG7_COLON_DP_EN defined)
//   an_n        : active-low one-hot digit anodes
//   seg_n       : active-low segments {g,f,e,d,c,b,a}
//   dp_n        : active-low decimal point
//   frame_start : one-cycle pulse when a new snapshot is taken
// modport master = digit source / display observer, modport slave = driver.
// Optional feature macro: SEG7_COLON_DP_EN
// ---------------------------------------------------------------------------
interface seg7_scan_driver_if;
  import clock_disp_pkg::*;

  bcd_t       bcd0;
  bcd_t       bcd1;
  bcd_t       bcd2;
  bcd_t       bcd3;
`ifdef SEG7_COLON_DP_EN
  logic       dp_colon;
`endif
  logic [3:0] an_n;
  seg_t       seg_n;
  logic       dp_n;
  logic       frame_start;

`ifdef SEG7_COLON_DP_EN
  modport master (output bcd0, bcd1, bcd2, bcd3, dp_colon,
                  input  an_n, seg_n, dp_n, frame_start);
  modport slave  (input  bcd0, bcd1, bcd2, bcd3, dp_colon,
                  output an_n, seg_n, dp_n, frame_start);
`else
  modport master (output bcd0, bcd1, bcd2, bcd3,
                  input  an_n, seg_n, dp_n, frame_start);
  modport slave  (input  bcd0, bcd1, bcd2, bcd3,
                  output an_n, seg_n, dp_n, frame_start);
`endif

endinterface

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
// Purely combinational decoder from a 4-bit digit code to an active-low
// 7-segment pattern: 0..9 digits, 10..14 a dash, 15 blank.
//   i_bcd : digit code
//   o_seg : segments {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module bcd_to_seg7
  import clock_disp_pkg::*;
(
  input  bcd_t i_bcd,
  output seg_t o_seg
);

  // Codes above 9 are not digits: the blank code gets a dark digit so the
  // blink-off phase works, every other invalid code shows a dash so a bad
  // upstream value is visible rather than silently hidden.
  always_comb begin
    o_seg = SEG_DASH;
    if (i_bcd == BCD_BLANK) begin
      o_seg = SEG_BLANK;
    end else if (i_bcd < 4'd10) begin
      o_seg = SEG_DIGITS[i_bcd];
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed 4-digit 7-segment driver. Snapshots the four digit codes
// once per frame, lights one digit per slot of SCAN_DIV cycles, and keeps
// all anodes off for the first DEAD_CYCLES of each slot to avoid ghosting.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : seg7_scan_driver_if.slave (digits in, anodes/segments out)
// Parameters: SCAN_DIV (cycles per slot, >= 2),
//             DEAD_CYCLES (dark cycles per slot, 1 <= DEAD_CYCLES < SCAN_DIV)
// Optional feature macro: SEG7_COLON_DP_EN (adds dp_colon, lit in slot 2)
// ---------------------------------------------------------------------------
module seg7_scan_driver
  import clock_disp_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 500
)
(
  input  logic                clk,
  input  logic                rst_n,
  seg7_scan_driver_if.slave   bus
);

  localparam int             CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  DEAD_LIM = CW'(DEAD_CYCLES);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  bcd_t          r_snap [4];
  logic          r_frameStart;
  logic [3:0]    r_anN;
  seg_t          r_segN;

  logic          w_frameLoad;
  logic          w_dark;
  bcd_t          w_digit;
  seg_t          w_seg;

`ifdef SEG7_COLON_DP_EN
  logic          r_colon;
  logic          r_dpN;
`endif

  // A frame begins at the first cycle of slot 0. Dead time is guaranteed
  // there, so reloading the snapshot never changes a lit digit.
  assign w_frameLoad = (r_cnt == '0) && (r_idx == 2'd0);
  assign w_dark      = (r_cnt < DEAD_LIM);
  assign w_digit     = r_snap[r_idx];

  bcd_to_seg7 u_decode (
    .i_bcd (w_digit),
    .o_seg (w_seg)
  );

  // Slot counter and digit index. The index advances on the last cycle of
  // each slot and wraps naturally from 3 to 0 in two bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // Frame snapshot: all digits are latched together so a value changing
  // mid-frame never shows half old and half new.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_snap[i] <= BCD_BLANK;
      r_frameStart <= 1'b0;
    end else begin
      if (w_frameLoad) begin
        r_snap[0] <= bus.bcd0;
        r_snap[1] <= bus.bcd1;
        r_snap[2] <= bus.bcd2;
        r_snap[3] <= bus.bcd3;
      end
      r_frameStart <= w_frameLoad;
    end
  end

  // Registered display outputs, computed from this cycle's counter, index
  // and snapshot so the pins are glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_anN  <= 4'b1111;
      r_segN <= SEG_BLANK;
    end else if (w_dark) begin
      r_anN  <= 4'b1111;
      r_segN <= SEG_BLANK;
    end else begin
      r_anN  <= ~(4'b0001 << r_idx);
      r_segN <= w_seg;
    end
  end

`ifdef SEG7_COLON_DP_EN
  // Colon request is captured with the digits and shown as the decimal
  // point of digit 2, i.e. between bcd2 and bcd1, only while that digit is lit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_colon <= 1'b0;
      r_dpN   <= 1'b1;
    end else begin
      if (w_frameLoad) r_colon <= bus.dp_colon;
      r_dpN <= !(!w_dark && (r_idx == 2'd2) && r_colon);
    end
  end

  assign bus.dp_n = r_dpN;
`else
  assign bus.dp_n = 1'b1;
`endif

  assign bus.an_n        = r_anN;
  assign bus.seg_n       = r_segN;
  assign bus.frame_start = r_frameStart;

endmodule
